// File: rtl/mrv_sram_arb_pkg.sv
// Shared types for the imem/dmem SRAM port arbiter.
// State encoding, response owner tags and the request bundle.
package mrv_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int STARVE_W = 4;
    typedef logic [STARVE_W-1:0] starve_t;

    typedef struct packed {
        logic        cen;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    localparam sram_req_t REQ_NONE = '0;

    function automatic starve_t starve_inc(input starve_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mrv_sram_arbiter.sv
// Shares one SRAM port between imem and dmem: dmem priority, imem
// anti-starvation, grant locked across stalls, response routed to owner.
module mrv_sram_arbiter
    import mrv_sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit DMEM_FIRST   = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        imem_cen,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_stall,
    output logic        imem_error,
    output logic [31:0] imem_rdata,
    input  logic        dmem_cen,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_stall,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata
);

    localparam starve_t LIMIT = starve_t'(STARVE_LIMIT);

    arb_state_e state_q;
    starve_t    starve_q;
    logic       rsp_valid_q;
    logic       rsp_owner_q;

    sram_req_t  i_req;
    sram_req_t  d_req;
    sram_req_t  m_req;
    logic       gnt_i;
    logic       gnt_d;
    logic       i_wins;
    logic       acc_i;
    logic       own_i;
    logic       own_d;

    // Gating cen with reset keeps mem_cen and both stalls low while held.
    assign i_req = '{
        cen:   imem_cen & g_resetn,
        wen:   imem_wen,
        strb:  imem_strb,
        addr:  imem_addr,
        wdata: imem_wdata
    };

    assign d_req = '{
        cen:   dmem_cen & g_resetn,
        wen:   dmem_wen,
        strb:  dmem_strb,
        addr:  dmem_addr,
        wdata: dmem_wdata
    };

    assign i_wins = (starve_q >= LIMIT) || !DMEM_FIRST;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (state_q)
            LOCK_I: gnt_i = i_req.cen;
            LOCK_D: gnt_d = d_req.cen;
            default: begin
                if (i_req.cen && d_req.cen) begin
                    gnt_i = i_wins;
                    gnt_d = !i_wins;
                end else begin
                    gnt_i = i_req.cen;
                    gnt_d = d_req.cen;
                end
            end
        endcase
    end

    always_comb begin
        m_req = REQ_NONE;
        unique case (1'b1)
            gnt_i:   m_req = i_req;
            gnt_d:   m_req = d_req;
            default: m_req = REQ_NONE;
        endcase
    end

    assign mem_cen   = m_req.cen;
    assign mem_wen   = m_req.wen;
    assign mem_strb  = m_req.strb;
    assign mem_addr  = m_req.addr;
    assign mem_wdata = m_req.wdata;

    assign imem_stall = i_req.cen & (~gnt_i | mem_stall);
    assign dmem_stall = d_req.cen & (~gnt_d | mem_stall);

    assign acc_i = gnt_i & ~mem_stall;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWN_I;
        end else begin
            if (gnt_i && mem_stall) begin
                state_q <= LOCK_I;
            end else if (gnt_d && mem_stall) begin
                state_q <= LOCK_D;
            end else begin
                state_q <= IDLE;
            end
            if (acc_i) begin
                starve_q <= '0;
            end else if (imem_cen) begin
                starve_q <= starve_inc(starve_q);
            end
            rsp_valid_q <= mem_cen & ~mem_stall;
            rsp_owner_q <= gnt_d ? OWN_D : OWN_I;
        end
    end

    assign own_i = rsp_valid_q & (rsp_owner_q == OWN_I);
    assign own_d = rsp_valid_q & (rsp_owner_q == OWN_D);

    assign imem_rdata = own_i ? mem_rdata : '0;
    assign imem_error = own_i & mem_error;
    assign dmem_rdata = own_d ? mem_rdata : '0;
    assign dmem_error = own_d & mem_error;

endmodule

// File: tb/tb_mrv_sram_arbiter.sv
// Vector table plus response scoreboard for mrv_sram_arbiter.
// Default parameters: STARVE_LIMIT=4, DMEM_FIRST=1.
module tb_mrv_sram_arbiter;

    localparam logic [1:0] G_N = 2'd0;
    localparam logic [1:0] G_I = 2'd1;
    localparam logic [1:0] G_D = 2'd2;
    localparam logic [31:0] IW_X = 32'h1111_0000;
    localparam logic [31:0] DW_X = 32'h0000_AAAA;

    typedef struct {
        logic        ic;
        logic [31:0] ia;
        logic        dc;
        logic [31:0] da;
        logic        dw;
        logic [3:0]  ds;
        logic        ms;
        logic [31:0] rd;
        logic        er;
        logic [1:0]  gnt;
    } vec_t;

    typedef struct {
        logic valid;
        logic own;
    } rsp_t;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_cen, imem_wen;
    logic [3:0]  imem_strb;
    logic [31:0] imem_addr, imem_wdata;
    logic        imem_stall, imem_error;
    logic [31:0] imem_rdata;
    logic        dmem_cen, dmem_wen;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_stall, dmem_error;
    logic [31:0] dmem_rdata;
    logic        mem_cen, mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_error;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    rsp_t rsp_q[$];
    vec_t tbl[22];

    always #5 g_clk = ~g_clk;

    mrv_sram_arbiter dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .imem_cen   (imem_cen),
        .imem_wen   (imem_wen),
        .imem_strb  (imem_strb),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_stall (imem_stall),
        .imem_error (imem_error),
        .imem_rdata (imem_rdata),
        .dmem_cen   (dmem_cen),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_stall (dmem_stall),
        .dmem_error (dmem_error),
        .dmem_rdata (dmem_rdata),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_stall  (mem_stall),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata)
    );

    function automatic vec_t mk(
        input logic ic, input logic [31:0] ia,
        input logic dc, input logic [31:0] da,
        input logic dw, input logic [3:0] ds,
        input logic ms, input logic [31:0] rd,
        input logic er, input logic [1:0] gnt
    );
        vec_t v;
        v.ic = ic; v.ia = ia; v.dc = dc; v.da = da;
        v.dw = dw; v.ds = ds; v.ms = ms; v.rd = rd;
        v.er = er; v.gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        imem_cen   = v.ic;
        imem_wen   = 1'b0;
        imem_strb  = 4'hF;
        imem_addr  = v.ia;
        imem_wdata = v.ia ^ IW_X;
        dmem_cen   = v.dc;
        dmem_wen   = v.dw;
        dmem_strb  = v.ds;
        dmem_addr  = v.da;
        dmem_wdata = v.da ^ DW_X;
        mem_stall  = v.ms;
        mem_rdata  = v.rd;
        mem_error  = v.er;
    endtask

    // Called #1 after a rising edge; leaves #1 after the next one.
    task automatic step(input string tag, input vec_t v);
        rsp_t p;
        logic gi, gd, ri, rd_;
        drive(v);
        #4;
        p.valid = 1'b0;
        p.own = 1'b0;
        if (rsp_q.size() > 0) p = rsp_q.pop_front();
        gi = (v.gnt == G_I);
        gd = (v.gnt == G_D);
        ri = p.valid && !p.own;
        rd_ = p.valid && p.own;
        chk({tag, " mem_cen"}, 32'(mem_cen), 32'(gi | gd));
        chk({tag, " mem_addr"}, mem_addr,
            gi ? v.ia : (gd ? v.da : 32'h0));
        chk({tag, " mem_wdata"}, mem_wdata,
            gi ? (v.ia ^ IW_X) : (gd ? (v.da ^ DW_X) : 32'h0));
        chk({tag, " mem_wen"}, 32'(mem_wen), 32'(gd & v.dw));
        chk({tag, " mem_strb"}, 32'(mem_strb),
            gi ? 32'hF : (gd ? 32'(v.ds) : 32'h0));
        chk({tag, " imem_stall"}, 32'(imem_stall),
            32'(v.ic & (gi ? v.ms : 1'b1)));
        chk({tag, " dmem_stall"}, 32'(dmem_stall),
            32'(v.dc & (gd ? v.ms : 1'b1)));
        chk({tag, " imem_rdata"}, imem_rdata, ri ? v.rd : 32'h0);
        chk({tag, " dmem_rdata"}, dmem_rdata, rd_ ? v.rd : 32'h0);
        chk({tag, " imem_error"}, 32'(imem_error), 32'(ri & v.er));
        chk({tag, " dmem_error"}, 32'(dmem_error), 32'(rd_ & v.er));
        rsp_q.push_back('{valid: (gi | gd) & !v.ms, own: gd});
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0,     0, 0,     0, 0, 0, 0,            0, G_N);
        tbl[1]  = mk(1, 'h100, 0, 0,     0, 0, 0, 0,            0, G_I);
        tbl[2]  = mk(0, 0,     0, 0,     0, 0, 0, 'hDEADBEEF,   0, G_N);
        tbl[3]  = mk(1, 0,     1, 'h2000,0, 0, 0, 0,            0, G_D);
        tbl[4]  = mk(1, 0,     0, 0,     0, 0, 0, 'h11112222,   0, G_I);
        tbl[5]  = mk(1, 'h40,  1, 'h3000,0, 0, 1, 'h33334444,   0, G_D);
        tbl[6]  = mk(1, 'h40,  1, 'h3000,0, 0, 1, 'hBAD0,       1, G_D);
        tbl[7]  = mk(1, 'h40,  1, 'h3000,0, 0, 1, 'hBAD1,       1, G_D);
        tbl[8]  = mk(1, 'h40,  1, 'h3000,0, 0, 0, 'hBAD2,       0, G_D);
        tbl[9]  = mk(1, 'h40,  1, 'h3004,0, 0, 0, 'h55,         0, G_I);
        tbl[10] = mk(1, 'h80,  1, 'h4000,0, 0, 0, 'h66,         0, G_D);
        tbl[11] = mk(1, 'h80,  1, 'h4004,0, 0, 0, 'h67,         0, G_D);
        tbl[12] = mk(1, 'h80,  1, 'h4008,0, 0, 0, 'h68,         0, G_D);
        tbl[13] = mk(1, 'h80,  1, 'h400C,0, 0, 0, 'h69,         0, G_D);
        tbl[14] = mk(1, 'h80,  1, 'h4010,0, 0, 0, 'h6A,         0, G_I);
        tbl[15] = mk(1, 'h84,  1, 'h4014,0, 0, 0, 'h6B,         0, G_D);
        tbl[16] = mk(0, 0,     1, 'h5000,1, 4'b0011, 0, 'h6C,   0, G_D);
        tbl[17] = mk(0, 0,     0, 0,     0, 0, 0, 'h77,         1, G_N);
        tbl[18] = mk(1, 'h200, 0, 0,     0, 0, 1, 'h78,         1, G_I);
        tbl[19] = mk(0, 0,     1, 'h6000,1, 4'hF, 1, 0,         0, G_N);
        tbl[20] = mk(0, 0,     1, 'h6000,1, 4'hF, 0, 0,         0, G_D);
        tbl[21] = mk(0, 0,     0, 0,     0, 0, 0, 'h88,         1, G_N);

        g_resetn = 1'b0;
        drive(mk(1, 'h10, 1, 'h20, 1, 4'hF, 1, 'hFFFF, 1, G_N));
        #12;
        chk("rst mem_cen", 32'(mem_cen), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst imem_stall", 32'(imem_stall), 32'h0);
        chk("rst dmem_stall", 32'(dmem_stall), 32'h0);
        chk("rst imem_rdata", imem_rdata, 32'h0);
        chk("rst dmem_error", 32'(dmem_error), 32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step($sformatf("v%0d", i), tbl[i]);
        end

        // Enter LOCK_I, then pull reset mid-cycle while an accept is offered.
        step("lk", mk(1, 'h300, 0, 0, 0, 0, 1, 0, 0, G_I));
        drive(mk(1, 'h300, 0, 0, 0, 0, 0, 'h99, 1, G_N));
        #2;
        g_resetn = 1'b0;
        #1;
        chk("ar mem_cen", 32'(mem_cen), 32'h0);
        chk("ar imem_stall", 32'(imem_stall), 32'h0);
        chk("ar imem_rdata", imem_rdata, 32'h0);
        chk("ar imem_error", 32'(imem_error), 32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        rsp_q.delete();
        step("pr0", mk(0, 0,     0, 0,     0, 0, 0, 'h99, 1, G_N));
        step("pr1", mk(1, 'h300, 1, 'h7000,0, 0, 0, 0,    0, G_D));
        step("pr2", mk(1, 'h300, 0, 0,     0, 0, 0, 'hAB, 0, G_I));
        step("pr3", mk(0, 0,     0, 0,     0, 0, 0, 'hCD, 1, G_N));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrv_sram_arbiter.md
Name: mrv_sram_arbiter

Overview:
- Shares one downstream SRAM port between the CPU instruction port (imem) and data port (dmem).
- Used for single-memory mrv_cpu integrations: CPU-side ports connect to the core, the downstream port connects to one SRAM.
- Fixed priority to dmem, with an anti-starvation counter for imem.
- Grant is locked across downstream stalls; the one-cycle response (rdata/error) is routed back to the requester that owns it.

Parameters:
STARVE_LIMIT, 4, consecutive cycles imem may be requesting-but-not-accepted before it wins the next arbitration (range 1..15).
DMEM_FIRST, 1, 1: dmem wins a tie by default; 0: imem wins by default.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  asynchronous active-low reset
imem_cen  input  1  imem request
imem_wen  input  1  imem write enable
imem_strb  input  4  imem write strobe
imem_addr  input  32  imem address
imem_wdata  input  32  imem write data
imem_stall  output  1  imem stall
imem_error  output  1  imem response error
imem_rdata  output  32  imem read data
dmem_cen  input  1  dmem request
dmem_wen  input  1  dmem write enable
dmem_strb  input  4  dmem write strobe
dmem_addr  input  32  dmem address
dmem_wdata  input  32  dmem write data
dmem_stall  output  1  dmem stall
dmem_error  output  1  dmem response error
dmem_rdata  output  32  dmem read data
mem_cen  output  1  downstream request
mem_wen  output  1  downstream write enable
mem_strb  output  4  downstream strobe
mem_addr  output  32  downstream address
mem_wdata  output  32  downstream write data
mem_stall  input  1  downstream stall
mem_error  input  1  downstream error (response cycle)
mem_rdata  input  32  downstream read data (response cycle)

Behaviour:
- Protocol, all ports:
  - A request is accepted in a cycle with cen=1 and stall=0.
  - rdata/error are valid exactly one cycle after acceptance.
  - While stalled, the requester holds cen, wen, strb, addr and wdata stable.
- Grant selection is combinational from state and requests. The selected requester's cen/wen/strb/addr/wdata drive mem_*.
- mem_* outputs when nothing is granted, or while g_resetn=0: mem_cen=0, and wen/strb/addr/wdata=0.
- Stalls:
  - Granted requester: stall = mem_stall.
  - Non-granted requester with cen=1: stall=1.
  - Requester with cen=0: stall=0.
- States: IDLE, LOCK_I, LOCK_D. Reset state is IDLE.
- IDLE arbitration:
  - Only one side requesting: that side is granted.
  - Both requesting: imem wins if starve_cnt >= STARVE_LIMIT. Otherwise dmem wins if DMEM_FIRST=1, imem if DMEM_FIRST=0.
- Lock entry: if the granted request sees mem_stall=1, next state is LOCK_x for that requester.
- LOCK_x:
  - Grant is forced to x regardless of the other side or starve_cnt.
  - Exit to IDLE on acceptance (x_cen=1, mem_stall=0).
  - Exit to IDLE immediately if x_cen drops (protocol violation, tolerated). No request is issued downstream in that cycle from the lock.
- starve_cnt (4 bits, reset 0):
  - Increments, saturating at 15, each cycle imem_cen=1 and imem is not accepted.
  - Clears to 0 on imem acceptance.
  - Holds when imem_cen=0.
- Response tracking: rsp_valid_q and rsp_owner_q (0=imem, 1=dmem), reset 0/0. Each cycle:
  - rsp_valid_q <= (mem_cen & ~mem_stall).
  - rsp_owner_q <= granted requester.
- Response routing:
  - When rsp_valid_q=1: the owner's rdata = mem_rdata and error = mem_error; the other side gets rdata=0 and error=0.
  - When rsp_valid_q=0: both rdata=0 and error=0.
- Back-to-back: a new acceptance can occur in the same cycle as the previous response is delivered, giving full throughput of one access per cycle.
- Reset mid-operation: asynchronous assertion immediately forces IDLE, starve_cnt=0 and rsp_valid_q=0. Any in-flight response is dropped.
- Reset values of outputs: imem_stall=0, dmem_stall=0, both error=0, both rdata=0, mem_cen=0.

Decomposition:
- Shared package mrv_sram_arb_pkg:
  - State encoding: IDLE=2'd0, LOCK_I=2'd1, LOCK_D=2'd2.
  - Owner constants: OWN_I=1'b0, OWN_D=1'b1.
  - Starve counter width: 4.
- No sub-module is needed; the block is a single FSM plus counter plus response register.
- The formal harness binds the team's SRAM interface checker to all three ports.

Test Plan:
- Single imem read: imem_cen=1, addr=0x100, mem_stall=0, mem_rdata=0xDEADBEEF next cycle -> mem_addr=0x100 same cycle; imem_rdata=0xDEADBEEF one cycle later; dmem_rdata=0.
- Simultaneous requests, DMEM_FIRST=1: imem addr=0x0, dmem addr=0x2000, both cen=1 -> mem_addr=0x2000, imem_stall=1, dmem_stall=0. Next cycle (dmem_cen=0): mem_addr=0x0 and dmem_rdata carries the first response.
- Stall lock: dmem granted with mem_stall=1 for 3 cycles while imem_cen=1 and starve_cnt reaches 4 -> grant stays dmem (LOCK_D) all 3 cycles; mem_addr stays constant; imem granted the cycle after dmem is accepted.
- Starvation: dmem_cen=1 continuously, imem_cen=1, STARVE_LIMIT=4 -> dmem is accepted 4 times, imem is accepted on the 5th cycle, starve_cnt returns to 0.
- Error routing: dmem write accepted, mem_error=1 next cycle -> dmem_error=1, imem_error=0; write with strb=4'b0011 appears unchanged on mem_strb.
- Async reset during LOCK_I with pending response: g_resetn=0 mid-cycle -> mem_cen=0 and imem_stall=0 immediately; no rdata/error delivered; after release, a fresh imem request is granted from IDLE.
